out_stream_buffer: RTL

- Downstream stage for the registered out_data/out_valid stream of the core datapath block.
- That stream has no backpressure, so this block absorbs it in a small FIFO and re-emits it as a valid/ready stream to the consumer.
- Counts words dropped on overflow and flags marker words (default 0xAA) at the output head.
- Gives the assertion-derived monitors a stable, checkable handshake to observe.

---
 rtl/out_stream_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/out_stream_buffer.sv
// Small first-word-fall-through FIFO that turns a stream with no backpressure into a valid/ready stream.
// Words that arrive while the FIFO is full are counted as drops and raise a sticky overflow flag.
module out_stream_buffer #(
  parameter int                 DATA_W = 8,
  parameter int                 DEPTH  = 4,
  parameter logic [DATA_W-1:0]  MARKER = 8'hAA,
  parameter int                 CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  input  logic                     m_ready,
  output logic                     m_marker,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign m_valid  = !empty;
  assign m_data   = mem[rd_ptr];
  assign m_marker = m_valid && (m_data == MARKER);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a word.
  assign pop  = m_valid && m_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage has no reset; only pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
